spi_display_rx: RTL and testbench

Receive-side model and decoder for the 4-wire display SPI link (SCLK, MOSI, D/C, CS) that the line-drawing transmitter drives. It oversamples the link on the system clock, assembles MSB-first bytes, and interprets the ILI9341-style command set (CASET 0x2A, PASET 0x2B, RAMWR 0x2C). For every RGB565 pixel written it emits a one-cycle pixel strobe with the auto-incremented (x, y) address. It is used as the display stand-in for closed-loop verification of drawing blocks and as an on-FPGA link monitor.

---
 rtl/spi_display_rx_pkg.sv | 32 +++
 rtl/spi_display_rx_byte_rx.sv | 81 ++++++++
 rtl/spi_display_rx.sv | 159 +++++++++++++++
 tb/tb_spi_display_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_display_rx_pkg.sv
// Shared definitions for the display SPI receiver: opcodes, power-on window
// bounds and decoder state encoding.
package spi_display_rx_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Power-on window matches a 240x320 portrait panel.
  localparam logic [15:0] DEF_XS = 16'd0;
  localparam logic [15:0] DEF_XE = 16'd239;
  localparam logic [15:0] DEF_YS = 16'd0;
  localparam logic [15:0] DEF_YE = 16'd319;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CASET_P = 3'd1,
    ST_PASET_P = 3'd2,
    ST_RAMWR_D = 3'd3,
    ST_IGNORE  = 3'd4
  } state_t;

  function automatic state_t cmd_to_state(input logic [7:0] c);
    case (c)
      CMD_CASET: cmd_to_state = ST_CASET_P;
      CMD_PASET: cmd_to_state = ST_PASET_P;
      CMD_RAMWR: cmd_to_state = ST_RAMWR_D;
      default:   cmd_to_state = ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spi_display_rx_byte_rx.sv
// Oversampling SPI byte receiver: synchronizes the link, detects SCLK rising
// edges, assembles MSB-first bytes and flags bytes cut short by CS.
module spi_byte_rx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic       i_cs,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_byte_dc,
  output logic       o_err
);

  logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic       r_mosi_s1, r_mosi_s2;
  logic       r_dc_s1, r_dc_s2;
  logic       r_cs_s1, r_cs_s2;
  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic       r_byte_valid;
  logic [7:0] r_byte;
  logic       r_byte_dc;
  logic       r_err;
  logic       w_rise;
  logic [7:0] w_shift_next;

  assign w_rise       = r_sclk_s2 & ~r_sclk_d;
  assign w_shift_next = {r_shift[6:0], r_mosi_s2};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_s1    <= 1'b0;
      r_sclk_s2    <= 1'b0;
      r_sclk_d     <= 1'b0;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_dc_s1      <= 1'b0;
      r_dc_s2      <= 1'b0;
      r_cs_s1      <= 1'b1;
      r_cs_s2      <= 1'b1;
      r_shift      <= 8'h00;
      r_cnt        <= 3'd0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'h00;
      r_byte_dc    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sclk_s1    <= i_sclk;
      r_sclk_s2    <= r_sclk_s1;
      r_sclk_d     <= r_sclk_s2;
      r_mosi_s1    <= i_mosi;
      r_mosi_s2    <= r_mosi_s1;
      r_dc_s1      <= i_dc;
      r_dc_s2      <= r_dc_s1;
      r_cs_s1      <= i_cs;
      r_cs_s2      <= r_cs_s1;
      r_byte_valid <= 1'b0;
      // CS deassertion aborts any partial byte; a nonzero count means bits were lost.
      if (r_cs_s2) begin
        r_cnt <= 3'd0;
        if (r_cnt != 3'd0) r_err <= 1'b1;
      end else if (w_rise) begin
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_byte_valid <= 1'b1;
          r_byte       <= w_shift_next;
          r_byte_dc    <= r_dc_s2;
        end
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_byte;
  assign o_byte_dc    = r_byte_dc;
  assign o_err        = r_err;

endmodule

// File: rtl/spi_display_rx.sv
// Display SPI receiver top: decodes CASET/PASET/RAMWR from the byte stream and
// strobes each RGB565 pixel with its auto-incremented window address.
module spi_display_rx
  import spi_display_rx_pkg::*;
#(
  parameter int XW = 9,
  parameter int YW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sclk,
  input  logic          i_mosi,
  input  logic          i_dc,
  input  logic          i_cs,
  output logic          o_cmd_valid,
  output logic [7:0]    o_cmd,
  output logic          o_px_valid,
  output logic [XW-1:0] o_px_x,
  output logic [YW-1:0] o_px_y,
  output logic [15:0]   o_px_data,
  output logic          o_err
);

  logic          w_byte_valid;
  logic [7:0]    w_byte;
  logic          w_byte_dc;
  logic [15:0]   w_param;
  state_t        r_state, w_state_next;
  logic [1:0]    r_idx;
  logic [7:0]    r_phi;
  logic [15:0]   r_pstart;
  logic [XW-1:0] r_xs, r_xe, r_cur_x;
  logic [YW-1:0] r_ys, r_ye, r_cur_y;
  logic [7:0]    r_pix_hi;
  logic          r_phase;
  logic          r_cmd_valid, r_px_valid;
  logic [7:0]    r_cmd;
  logic [XW-1:0] r_px_x;
  logic [YW-1:0] r_px_y;
  logic [15:0]   r_px_data;

  spi_byte_rx u_byte_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sclk       (i_sclk),
    .i_mosi       (i_mosi),
    .i_dc         (i_dc),
    .i_cs         (i_cs),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_byte_dc    (w_byte_dc),
    .o_err        (o_err)
  );

  assign w_param = {r_phi, w_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_byte_valid) begin
      if (!w_byte_dc) begin
        w_state_next = cmd_to_state(w_byte);
      end else if ((r_state == ST_CASET_P || r_state == ST_PASET_P) && r_idx == 2'd3) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx       <= 2'd0;
      r_phi       <= 8'h00;
      r_pstart    <= 16'h0000;
      r_xs        <= DEF_XS[XW-1:0];
      r_xe        <= DEF_XE[XW-1:0];
      r_ys        <= DEF_YS[YW-1:0];
      r_ye        <= DEF_YE[YW-1:0];
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_pix_hi    <= 8'h00;
      r_phase     <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= 8'h00;
      r_px_valid  <= 1'b0;
      r_px_x      <= '0;
      r_px_y      <= '0;
      r_px_data   <= 16'h0000;
    end else begin
      r_cmd_valid <= 1'b0;
      r_px_valid  <= 1'b0;
      if (w_byte_valid) begin
        if (!w_byte_dc) begin
          r_cmd_valid <= 1'b1;
          r_cmd       <= w_byte;
          r_idx       <= 2'd0;
          if (w_byte == CMD_RAMWR) begin
            r_cur_x <= r_xs;
            r_cur_y <= r_ys;
            r_phase <= 1'b0;
          end
        end else begin
          case (r_state)
            ST_CASET_P, ST_PASET_P: begin
              r_idx <= r_idx + 2'd1;
              case (r_idx)
                2'd0: r_phi <= w_byte;
                2'd1: r_pstart <= w_param;
                2'd2: r_phi <= w_byte;
                2'd3: begin
                  // Start and end commit together so a half-written window never takes effect.
                  if (r_state == ST_CASET_P) begin
                    r_xs <= r_pstart[XW-1:0];
                    r_xe <= w_param[XW-1:0];
                  end else begin
                    r_ys <= r_pstart[YW-1:0];
                    r_ye <= w_param[YW-1:0];
                  end
                end
                default: ;
              endcase
            end
            ST_RAMWR_D: begin
              if (!r_phase) begin
                r_pix_hi <= w_byte;
                r_phase  <= 1'b1;
              end else begin
                r_phase    <= 1'b0;
                r_px_valid <= 1'b1;
                r_px_x     <= r_cur_x;
                r_px_y     <= r_cur_y;
                r_px_data  <= {r_pix_hi, w_byte};
                // Equality-only wrap: an inverted window runs to 2^XW and rolls over.
                if (r_cur_x == r_xe) begin
                  r_cur_x <= r_xs;
                  r_cur_y <= (r_cur_y == r_ye) ? r_ys : r_cur_y + YW'(1);
                end else begin
                  r_cur_x <= r_cur_x + XW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd       = r_cmd;
  assign o_px_valid  = r_px_valid;
  assign o_px_x      = r_px_x;
  assign o_px_y      = r_px_y;
  assign o_px_data   = r_px_data;

endmodule

// File: tb/tb_spi_display_rx.sv
// Scoreboard bench for spi_display_rx: directed SPI traffic with expected
// strobes queued at issue time and checked by an independent monitor.
module tb_spi_display_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        dc = 1'b0;
  logic        cs = 1'b1;
  logic        cmd_valid, px_valid, err;
  logic [7:0]  cmd;
  logic [8:0]  px_x, px_y;
  logic [15:0] px_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit          is_px;
    logic [7:0]  cmd;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  spi_display_rx #(.XW(9), .YW(9)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_dc        (dc),
    .i_cs        (cs),
    .o_cmd_valid (cmd_valid),
    .o_cmd       (cmd),
    .o_px_valid  (px_valid),
    .o_px_x      (px_x),
    .o_px_y      (px_y),
    .o_px_data   (px_data),
    .o_err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = no strobe expected, 1 = command strobe, 2 = pixel strobe
  task automatic send_bits(input logic [7:0] b, input int n, input logic d,
                           input int kind, input logic [8:0] ex, input logic [8:0] ey,
                           input logic [15:0] ed);
    exp_t t;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      dc   = d;
      #40;
      sclk = 1'b1;
      if (i == 7 && kind != 0) begin
        t.is_px = (kind == 2);
        t.cmd   = b;
        t.x     = ex;
        t.y     = ey;
        t.d     = ed;
        t.cyc   = cyc + 4;
        q.push_back(t);
      end
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_bits(b, 8, 1'b0, 1, 9'd0, 9'd0, 16'h0);
  endtask

  task automatic send_dat(input logic [7:0] b);
    send_bits(b, 8, 1'b1, 0, 9'd0, 9'd0, 16'h0);
  endtask

  task automatic send_px(input logic [15:0] d, input logic [8:0] x, input logic [8:0] y);
    send_bits(d[15:8], 8, 1'b1, 0, 9'd0, 9'd0, 16'h0);
    send_bits(d[7:0], 8, 1'b1, 2, x, y, d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (cmd_valid || px_valid)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: cmd_valid=%0b px_valid=%0b cmd=0x%0h x=%0d y=%0d, want no strobe",
                 cmd_valid, px_valid, cmd, px_x, px_y);
      end else begin
        e = q.pop_front();
        if (e.is_px) begin
          if (!px_valid || cmd_valid || px_x !== e.x || px_y !== e.y || px_data !== e.d || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL pixel_strobe: got v=%0b x=%0d y=%0d d=0x%0h cyc=%0d, want x=%0d y=%0d d=0x%0h cyc=%0d",
                     px_valid, px_x, px_y, px_data, cyc, e.x, e.y, e.d, e.cyc);
          end
        end else begin
          if (!cmd_valid || px_valid || cmd !== e.cmd || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL cmd_strobe: got v=%0b cmd=0x%0h cyc=%0d, want cmd=0x%0h cyc=%0d",
                     cmd_valid, cmd, cyc, e.cmd, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #20;
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd", {24'd0, cmd}, 32'h00);
    chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
    chk("rst_px_x", {23'd0, px_x}, 32'd0);
    chk("rst_px_y", {23'd0, px_y}, 32'd0);
    chk("rst_px_data", {16'd0, px_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Default window after reset: pixels walk from (0,0).
    cs = 1'b0;
    #40;
    send_cmd(8'h2C);
    send_px(16'hA1B2, 9'd0, 9'd0);
    send_px(16'hC3D4, 9'd1, 9'd0);
    #80;
    chk("cmd_after_ramwr", {24'd0, cmd}, 32'h2C);

    // Reset pulse in the middle of a byte.
    send_bits(8'h2A, 3, 1'b0, 0, 9'd0, 9'd0, 16'h0);
    rst = 1'b1;
    #10;
    rst = 1'b0;
    #1;
    chk("midrst_cmd", {24'd0, cmd}, 32'h00);
    chk("midrst_px_data", {16'd0, px_data}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    #9;
    cs = 1'b1;
    #80;
    chk("midrst_err_after_cs", {31'd0, err}, 32'd0);
    cs = 1'b0;
    #40;

    send_cmd(8'h2A);
    #80;
    chk("cmd_caset", {24'd0, cmd}, 32'h2A);
    send_dat(8'd0); send_dat(8'd12); send_dat(8'd0); send_dat(8'd13);
    send_cmd(8'h2B);
    send_dat(8'd0); send_dat(8'd5); send_dat(8'd0); send_dat(8'd6);
    send_cmd(8'h2C);
    send_px(16'hF800, 9'd12, 9'd5);
    send_px(16'h07E0, 9'd13, 9'd5);
    send_px(16'h001F, 9'd12, 9'd6);
    send_px(16'hFFFF, 9'd13, 9'd6);
    send_px(16'h1234, 9'd12, 9'd5);

    // CS abort after 5 bits.
    chk("err_before_abort", {31'd0, err}, 32'd0);
    send_bits(8'hFF, 5, 1'b1, 0, 9'd0, 9'd0, 16'h0);
    cs = 1'b1;
    #80;
    chk("err_after_abort", {31'd0, err}, 32'd1);
    cs = 1'b0;
    #40;
    send_cmd(8'h2C);
    #80;
    chk("cmd_after_abort", {24'd0, cmd}, 32'h2C);

    // Unknown command swallows its data; window must survive.
    send_cmd(8'h36);
    send_dat(8'hAA);
    send_dat(8'h55);
    #80;
    chk("cmd_unknown", {24'd0, cmd}, 32'h36);
    send_cmd(8'h2C);
    send_px(16'hBEEF, 9'd12, 9'd5);
    send_px(16'h0F0F, 9'd13, 9'd5);
    #80;
    cs = 1'b1;
    #200;
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
